// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaled period counter, per-channel
// shadowed duty registers applied at the period boundary. Optional centre-aligned
// (up/down) counting is compiled in when PWM_MULTI_CENTER_EN is defined.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic [CHANNELS-1:0]   duty_wr,
    input  logic [WIDTH-1:0]      duty_in,
    input  logic                  center,
    output logic [CHANNELS-1:0]   pwm_o,
    output logic                  period_start
);

    localparam logic [WIDTH-1:0]      CNT_ONE   = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      cnt_nxt;
    logic [WIDTH-1:0]      period_act;
    logic [WIDTH-1:0]      duty_sh  [CHANNELS];
    logic [WIDTH-1:0]      duty_act [CHANNELS];
    logic [CHANNELS-1:0]   duty_hit;
    logic                  tick;
    logic                  wrap;

`ifdef PWM_MULTI_CENTER_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t dir;
    dir_t dir_nxt;
    logic center_act;
`else
    logic unused_center;
    assign unused_center = center;
`endif

    // Prescaler tick; the >= compare lets a smaller prescale take effect at once.
    assign tick = en && (presc_cnt >= prescale);

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_nxt = cnt;
        wrap    = 1'b0;
`ifdef PWM_MULTI_CENTER_EN
        dir_nxt = dir;
        if (tick) begin
            if (center_act) begin
                if (dir == DIR_UP) begin
                    if (cnt >= period_act) begin
                        // A top of 0 or 1 means the next step down already lands on 0.
                        if (period_act <= CNT_ONE) begin
                            cnt_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                            dir_nxt = DIR_DOWN;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    if (cnt <= CNT_ONE) begin
                        cnt_nxt = '0;
                        dir_nxt = DIR_UP;
                        wrap    = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            end else if (cnt == period_act) begin
                cnt_nxt = '0;
                wrap    = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
`else
        if (tick) begin
            if (cnt == period_act) begin
                cnt_nxt = '0;
                wrap    = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
`endif
    end

    always_comb begin
        duty_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_hit[i] = (cnt < duty_act[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            period_act   <= '0;
            period_start <= 1'b0;
            pwm_o        <= '0;
        end else if (!en) begin
            // Idle: keep reloading so the first period after enable is current.
            presc_cnt    <= '0;
            cnt          <= '0;
            period_act   <= period;
            period_start <= 1'b0;
            pwm_o        <= '0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + PRESC_ONE;
            cnt          <= cnt_nxt;
            period_start <= wrap;
            pwm_o        <= duty_hit;
            if (wrap) begin
                period_act <= period;
            end
        end
    end

`ifdef PWM_MULTI_CENTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir        <= DIR_UP;
            center_act <= 1'b0;
        end else if (!en) begin
            dir        <= DIR_UP;
            center_act <= center;
        end else begin
            dir <= dir_nxt;
            if (wrap) begin
                center_act <= center;
            end
        end
    end
`endif

    // NOTE: the duty arrays are a handful of flops, not a RAM, so clearing them
    // in reset is cheap and keeps the outputs defined from the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // duty_act takes the pre-edge shadow, so a write on the wrap edge waits one period.
                if (!en || wrap) begin
                    duty_act[i] <= duty_sh[i];
                end
                if (duty_wr[i]) begin
                    duty_sh[i] <= duty_in;
                end
            end
        end
    end

endmodule
